// File: rtl/dff_mem_master.sv
// dff_mem_master: request/stream front end for the dff_mem byte RAM.
// Converts valid/ready burst requests into one-cycle RAM strobes:
// mem_rin (read, active-high) and mem_rout_n (write, active-low).
//
// Handshake rule for req, wd and rd: a beat moves on a rising edge where
// valid && ready are both high; the initiator holds valid and its payload
// stable until that edge, and inputs are ignored while ready is low.
module dff_mem_master #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int RAM_BYTES = 16,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rin,
    output logic              mem_rout_n,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_DATA = 3'd1;
    localparam logic [2:0] S_WR_STB  = 3'd2;
    localparam logic [2:0] S_RD_STB  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_RD_HOLD = 3'd5;

    localparam int                WAIT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(RAM_BYTES);

    logic [2:0]        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              wd_ready_q, wd_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rin_q, mem_rin_d;
    logic              mem_rout_n_q, mem_rout_n_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [3:0]        beats_q, beats_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              req_legal;
    logic [ADDR_W-1:0] next_addr;

    // Start address legality and wrap at the RAM depth, not at 2**ADDR_W.
    always_comb begin
        req_legal = ({1'b0, req_addr} < DEPTH);
        next_addr = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_W'(1);
    end

    // Burst FSM: strobes are set on entry to the *_STB states so each is one cycle wide.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        wd_ready_d   = wd_ready_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        err_d        = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rin_d    = 1'b0;
        mem_rout_n_d = 1'b1;
        cur_addr_d   = cur_addr_q;
        beats_d      = beats_q;
        wait_d       = wait_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    if (req_legal) begin
                        req_ready_d = 1'b0;
                        cur_addr_d  = req_addr;
                        beats_d     = req_len;
                        if (req_write) begin
                            wd_ready_d = 1'b1;
                            state_d    = S_WR_DATA;
                        end else begin
                            mem_addr_d = req_addr;
                            mem_rin_d  = 1'b1;
                            state_d    = S_RD_STB;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WR_DATA: begin
                if (wd_valid && wd_ready_q) begin
                    mem_wdata_d  = wd_data;
                    mem_addr_d   = cur_addr_q;
                    wd_ready_d   = 1'b0;
                    mem_rout_n_d = 1'b0;
                    state_d      = S_WR_STB;
                end
            end
            S_WR_STB: begin
                cur_addr_d = next_addr;
                if (beats_q != 4'd0) begin
                    beats_d    = beats_q - 4'd1;
                    wd_ready_d = 1'b1;
                    state_d    = S_WR_DATA;
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_RD_STB: begin
                cur_addr_d = next_addr;
                wait_d     = WAIT_INIT;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == '0) begin
                    rd_data_d  = mem_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = S_RD_HOLD;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_RD_HOLD: begin
                if (rd_ready && rd_valid_q) begin
                    rd_valid_d = 1'b0;
                    if (beats_q != 4'd0) begin
                        beats_d    = beats_q - 4'd1;
                        mem_addr_d = cur_addr_q;
                        mem_rin_d  = 1'b1;
                        state_d    = S_RD_STB;
                    end else begin
                        req_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            wd_ready_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rin_q    <= 1'b0;
            mem_rout_n_q <= 1'b1;
            cur_addr_q   <= '0;
            beats_q      <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            wd_ready_q   <= wd_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rin_q    <= mem_rin_d;
            mem_rout_n_q <= mem_rout_n_d;
            cur_addr_q   <= cur_addr_d;
            beats_q      <= beats_d;
            wait_q       <= wait_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign wd_ready   = wd_ready_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign err        = err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rin    = mem_rin_q;
    assign mem_rout_n = mem_rout_n_q;
    assign dbg_state  = state_q;

endmodule
